// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: pipe results win, MDU results queue in a 2-entry FIFO
// and are forced through after StarveLimit lost cycles. Define WB_ARBITER_FWD_EN for forwarding outputs.
module wb_arbiter #(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5,
  parameter int StarveLimit  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pipe_we,
  input  logic [RegAddrWidth-1:0] pipe_addr,
  input  logic [DataWidth-1:0]    pipe_data,
  output logic                    pipe_stall,
  input  logic                    mdu_valid,
  input  logic [RegAddrWidth-1:0] mdu_addr,
  input  logic [DataWidth-1:0]    mdu_data,
  output logic                    mdu_ready,
  output logic                    rf_we,
  output logic [RegAddrWidth-1:0] rf_waddr,
  output logic [DataWidth-1:0]    rf_wdata
`ifdef WB_ARBITER_FWD_EN
  ,
  output logic                    fwd_valid,
  output logic [RegAddrWidth-1:0] fwd_addr,
  output logic [DataWidth-1:0]    fwd_data
`endif
);

  localparam int EntryWidth = RegAddrWidth + DataWidth;
  localparam logic [3:0] Limit = 4'(StarveLimit);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  state_t                    state_reg, state_next;
  logic [1:0]                count_reg, count_next;
  logic [3:0]                starve_reg, starve_next;
  logic                      rd_ptr_reg, wr_ptr_reg;
  logic                      pipe_stall_reg;
  logic                      rf_we_reg;
  logic [RegAddrWidth-1:0]   rf_waddr_reg;
  logic [DataWidth-1:0]      rf_wdata_reg;
  logic [EntryWidth-1:0]     entry_reg [2];

  logic                      pipe_req, fifo_has, push, pop, grant;
  logic [EntryWidth-1:0]     head;
  logic [RegAddrWidth-1:0]   grant_addr;
  logic [DataWidth-1:0]      grant_data;

  assign mdu_ready = (count_reg != 2'd2);
  assign pipe_req  = pipe_we && (pipe_addr != '0) && !pipe_stall_reg;
  assign fifo_has  = (count_reg != 2'd0);
  assign pop       = !pipe_req && fifo_has;
  // Zero-address MDU results complete the handshake but are dropped here.
  assign push      = mdu_valid && mdu_ready && (mdu_addr != '0);
  assign grant     = pipe_req || fifo_has;
  assign head      = entry_reg[rd_ptr_reg];
  assign grant_addr = pipe_req ? pipe_addr : head[EntryWidth-1:DataWidth];
  assign grant_data = pipe_req ? pipe_data : head[DataWidth-1:0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg[gi] <= {mdu_addr, mdu_data};
        end
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 2'd1;
    end else if (pop && !push) begin
      count_next = count_reg - 2'd1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    case (state_reg)
      IDLE: begin
        if (push) begin
          state_next  = PEND;
          starve_next = 4'd0;
        end
      end
      PEND: begin
        if (pop) begin
          starve_next = 4'd0;
          if (count_next == 2'd0) begin
            state_next = IDLE;
          end
        end else if (pipe_req) begin
          starve_next = starve_reg + 4'd1;
          if (starve_next >= Limit) begin
            state_next = FORCE;
          end
        end
      end
      FORCE: begin
        // The stall blocks the pipe, so the head is always popped here.
        starve_next = 4'd0;
        state_next  = (count_next != 2'd0) ? PEND : IDLE;
      end
      default: begin
        state_next  = IDLE;
        starve_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= 2'd0;
      starve_reg     <= 4'd0;
      rd_ptr_reg     <= 1'b0;
      wr_ptr_reg     <= 1'b0;
      pipe_stall_reg <= 1'b0;
      rf_we_reg      <= 1'b0;
      rf_waddr_reg   <= '0;
      rf_wdata_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      starve_reg     <= starve_next;
      pipe_stall_reg <= (state_next == FORCE);
      rf_we_reg      <= grant;
      if (pop) begin
        rd_ptr_reg <= !rd_ptr_reg;
      end
      if (push) begin
        wr_ptr_reg <= !wr_ptr_reg;
      end
      if (grant) begin
        rf_waddr_reg <= grant_addr;
        rf_wdata_reg <= grant_data;
      end
    end
  end

  assign pipe_stall = pipe_stall_reg;
  assign rf_we      = rf_we_reg;
  assign rf_waddr   = rf_waddr_reg;
  assign rf_wdata   = rf_wdata_reg;

`ifdef WB_ARBITER_FWD_EN
  assign fwd_valid = grant;
  assign fwd_addr  = grant_addr;
  assign fwd_data  = grant_data;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic checked against a
// queue-based reference model of the writeback arbitration rules.
module tb_wb_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pipe_we;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_data;
  logic          pipe_stall;
  logic          mdu_valid;
  logic [AW-1:0] mdu_addr;
  logic [DW-1:0] mdu_data;
  logic          mdu_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  always #5 clk = ~clk;

  wb_arbiter #(.DataWidth(DW), .RegAddrWidth(AW), .StarveLimit(LIM)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending MDU results, lost-cycle tally, stall flag, expected writeback.
  logic [AW+DW-1:0] mq[$];
  int               m_starve = 0;
  bit               m_stall = 0;
  bit               hold_pending = 0;
  logic [AW+DW:0]   held;
  logic             exp_we = 1'b0;
  logic [AW-1:0]    exp_addr = '0;
  logic [DW-1:0]    exp_data = '0;

  task automatic cycle(input bit rst, input bit pwe_in, input logic [AW-1:0] pa_in,
                       input logic [DW-1:0] pd_in, input bit mv, input logic [AW-1:0] ma,
                       input logic [DW-1:0] md);
    bit            we, pv, push, rdy;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    {we, a, d} = {pwe_in, pa_in, pd_in};
    // The upstream stage re-presents the request it showed during a stall.
    if (hold_pending && !rst) {we, a, d} = held;
    reset = rst; pipe_we = we; pipe_addr = a; pipe_data = d;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
    #1;
    rdy = (mq.size() < 2);
    check_eq("mdu_ready", mdu_ready, rdy);
    if (rst) begin
      mq.delete();
      m_starve = 0; m_stall = 0; hold_pending = 0;
      exp_we = 0; exp_addr = '0; exp_data = '0;
    end else begin
      pv   = we && (a != 0) && !m_stall;
      push = mv && rdy && (ma != 0);
      if (pv) begin
        exp_we = 1; exp_addr = a; exp_data = d;
        if (mq.size() > 0) m_starve++;
      end else if (mq.size() > 0) begin
        {exp_addr, exp_data} = mq.pop_front();
        exp_we = 1;
        m_starve = 0;
      end else begin
        exp_we = 0;
      end
      if (push) mq.push_back({ma, md});
      hold_pending = m_stall;
      if (m_stall) held = {we, a, d};
      m_stall = (m_starve >= LIM);
    end
    @(posedge clk);
    #1;
    check_eq("rf_we", rf_we, exp_we);
    check_eq("rf_waddr", rf_waddr, exp_addr);
    check_eq("rf_wdata", rf_wdata, exp_data);
    check_eq("pipe_stall", pipe_stall, m_stall);
    $display("cyc rst=%0d pipe=%0d/%0h/%0h mdu=%0d/%0h/%0h -> rf=%0d/%0h/%0h stall=%0d",
             rst, we, a, d, mv, ma, md, rf_we, rf_waddr, rf_wdata, pipe_stall);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    reset = 1; pipe_we = 0; pipe_addr = '0; pipe_data = '0;
    mdu_valid = 0; mdu_addr = '0; mdu_data = '0;
    cycle(1, 0, '0, '0, 0, '0, '0);
    cycle(1, 0, '0, '0, 0, '0, '0);
    check_eq("reset_ready", mdu_ready, 1);
    check_eq("reset_rf_we", rf_we, 0);
    check_eq("reset_stall", pipe_stall, 0);

    // Plain pipe write.
    cycle(0, 1, 5'd3, 32'hA5A5A5A5, 0, '0, '0);
    check_eq("pipe_we_dir", rf_we, 1);
    check_eq("pipe_addr_dir", rf_waddr, 3);
    check_eq("pipe_data_dir", rf_wdata, 32'hA5A5A5A5);
    check_eq("pipe_nostall", pipe_stall, 0);

    // Zero-address MDU result is swallowed.
    cycle(0, 0, '0, '0, 1, 5'd0, 32'h55);
    check_eq("mdu_zero_we", rf_we, 0);
    check_eq("mdu_zero_ready", mdu_ready, 1);
    idle(1);

    // Pipe write to r0 yields to a buffered MDU entry.
    cycle(0, 0, '0, '0, 1, 5'd7, 32'h11);
    cycle(0, 1, 5'd0, 32'hDEAD, 0, '0, '0);
    check_eq("r0_mdu_addr", rf_waddr, 7);
    check_eq("r0_mdu_data", rf_wdata, 32'h11);
    idle(2);

    // Starvation: four pipe wins, a forced MDU slot, then the held pipe write.
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, 5'(i + 1), 32'h100 + i, (i == 0), 5'd9, 32'h99);
      if (i == 4) check_eq("starve_stall", pipe_stall, 1);
      if (i == 5) begin
        check_eq("forced_addr", rf_waddr, 9);
        check_eq("forced_unstall", pipe_stall, 0);
      end
      if (i == 6) check_eq("held_addr", rf_waddr, 6);
    end
    idle(2);

    // Full FIFO under continuous pipe traffic; a third result waits for the forced pop.
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 5'd20, 32'h200 + i, 1, 5'(10 + (i > 1 ? 2 : i)), 32'h300 + i);
      if (i == 1) check_eq("full_ready", mdu_ready, 0);
      if (i == 4) check_eq("full_ready_hold", mdu_ready, 0);
      if (i == 5) check_eq("ready_after_pop", mdu_ready, 1);
    end
    idle(4);

    // Reset while forcing with two entries buffered.
    for (int i = 0; i < 5; i++) cycle(0, 1, 5'd21, 32'h400 + i, (i < 2), 5'(14 + i), 32'h500 + i);
    check_eq("pre_reset_stall", pipe_stall, 1);
    cycle(1, 1, 5'd22, 32'h600, 1, 5'd16, 32'h700);
    check_eq("rst_rf_we", rf_we, 0);
    check_eq("rst_rf_waddr", rf_waddr, 0);
    check_eq("rst_rf_wdata", rf_wdata, 0);
    check_eq("rst_stall", pipe_stall, 0);
    check_eq("rst_ready", mdu_ready, 1);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), $urandom(),
            ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom());
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
